// File: rtl/alu_op_issue.sv
// Issue stage in front of the 64-bit ALU: decodes RV64 fields into ALUop/a/b
// and buffers them in a small FIFO; illegal encodings are dropped and counted.
module alu_op_issue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        ALUop,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              illegal,
  output logic [CNT_W-1:0]  illegal_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  entry_t             hold_q, hold_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     cnt_q, cnt_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   ill_cnt_q, ill_cnt_d;

  entry_t            dec;
  logic              legal;
  logic [DATA_W-1:0] imm_i, imm_s;
  logic              accept, push, pop;
  entry_t            head;
  logic              unused_rs1_field;

  // rs1 index bits are resolved by register read; only the data is used here.
  assign unused_rs1_field = ^instr[19:15];

  assign imm_i = {{(DATA_W-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(DATA_W-12){instr[31]}}, instr[31:25], instr[11:7]};

  always_comb begin
    legal  = 1'b1;
    dec.op = OP_ADD;
    dec.a  = rs1_data;
    dec.b  = rs2_data;
    case (instr[6:0])
      7'b0110011: begin
        case (instr[14:12])
          3'b000:  dec.op = instr[30] ? OP_SUB : OP_ADD;
          3'b111:  dec.op = OP_AND;
          3'b110:  dec.op = OP_OR;
          default: legal  = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec.b = imm_i;
        case (instr[14:12])
          3'b000:  dec.op = OP_ADD;
          3'b111:  dec.op = OP_AND;
          3'b110:  dec.op = OP_OR;
          default: legal  = 1'b0;
        endcase
      end
      7'b0000011: dec.b = imm_i;
      7'b0100011: dec.b = imm_s;
      7'b1100011: begin
        dec.op = OP_SUB;
        if (instr[14:13] != 2'b00) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  assign in_ready  = (cnt_q < FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];

  // When empty the bus shows the last popped entry, not stale FIFO storage.
  assign ALUop         = out_valid ? head.op : hold_q.op;
  assign a             = out_valid ? head.a  : hold_q.a;
  assign b             = out_valid ? head.b  : hold_q.b;
  assign illegal       = illegal_q;
  assign illegal_count = ill_cnt_q;

  always_comb begin
    mem_d     = mem_q;
    hold_d    = hold_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    ill_cnt_d = ill_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = dec;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      hold_d   = head;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (accept && !legal) begin
      illegal_d = 1'b1;
      if (ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q     <= '0;
      hold_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      hold_q    <= hold_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: decode, FIFO ordering/backpressure,
// illegal counting with saturation, and mid-stream reset.
module tb_alu_op_issue;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] instr;
  logic [63:0] rs1_data, rs2_data;
  logic        out_valid, out_ready;
  logic [3:0]  ALUop;
  logic [63:0] a, b;
  logic        illegal;
  logic [7:0]  illegal_count;

  int errors = 0;
  int checks = 0;

  alu_op_issue #(.DATA_W(64), .DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUop(ALUop), .a(a), .b(b),
    .illegal(illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; instr = '0;
    rs1_data = '0; rs2_data = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_aluop",     64'(ALUop),     64'd0);
    check("rst_a",         a,              64'd0);
    check("rst_b",         b,              64'd0);
    check("rst_illegal",   64'(illegal),   64'd0);
    check("rst_count",     64'(illegal_count), 64'd0);

    // R-type add then sub, ALU always ready
    out_ready = 1'b1; rs1_data = 64'd5; rs2_data = 64'd3;
    in_valid = 1'b1; instr = 32'h0020_8033;
    tick();
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_op",    64'(ALUop),     64'd2);
    check("add_a",     a,              64'd5);
    check("add_b",     b,              64'd3);
    instr = 32'h4020_8033;
    tick();
    check("sub_valid", 64'(out_valid), 64'd1);
    check("sub_op",    64'(ALUop),     64'd6);
    in_valid = 1'b0;
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("hold_op",     64'(ALUop),     64'd6);
    check("hold_a",      a,              64'd5);

    // ADDI with imm = -1
    in_valid = 1'b1; instr = 32'hFFF0_8093; rs1_data = 64'd10;
    tick();
    in_valid = 1'b0;
    check("addi_op", 64'(ALUop), 64'd2);
    check("addi_a",  a,          64'd10);
    check("addi_b",  b,          64'hFFFF_FFFF_FFFF_FFFF);
    tick();

    // SD with imm = -8
    in_valid = 1'b1; instr = 32'hFE20_BC23; rs1_data = 64'd100;
    tick();
    in_valid = 1'b0;
    check("sd_op", 64'(ALUop), 64'd2);
    check("sd_a",  a,          64'd100);
    check("sd_b",  b,          64'hFFFF_FFFF_FFFF_FFF8);
    tick();

    // BEQ -> SUB on register operands
    in_valid = 1'b1; instr = 32'h0020_8063; rs1_data = 64'd9; rs2_data = 64'd4;
    tick();
    in_valid = 1'b0;
    check("beq_op", 64'(ALUop), 64'd6);
    check("beq_b",  b,          64'd4);
    tick();

    // Backpressure: add(a=1), or(a=2), and(a=3)
    out_ready = 1'b0; rs2_data = 64'd7;
    in_valid = 1'b1; instr = 32'h0020_8033; rs1_data = 64'd1;
    tick();
    check("bp1_in_ready", 64'(in_ready), 64'd1);
    instr = 32'h0020_E033; rs1_data = 64'd2;
    tick();
    check("bp2_in_ready", 64'(in_ready), 64'd0);
    check("bp2_head_a",   a,             64'd1);
    instr = 32'h0020_F033; rs1_data = 64'd3;
    tick();
    tick();
    check("bp_full_in_ready", 64'(in_ready), 64'd0);
    check("bp_stable_op",     64'(ALUop),    64'd2);
    check("bp_stable_a",      a,             64'd1);
    out_ready = 1'b1;
    tick();
    check("bp_pop1_op",       64'(ALUop),    64'd1);
    check("bp_pop1_a",        a,             64'd2);
    check("bp_pop1_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_third_valid", 64'(out_valid), 64'd1);
    check("bp_third_op",    64'(ALUop),     64'd0);
    check("bp_third_a",     a,              64'd3);
    tick();
    check("bp_empty_valid", 64'(out_valid), 64'd0);
    check("bp_empty_hold",  a,              64'd3);

    // Illegal opcode, then saturate the counter
    in_valid = 1'b1; instr = 32'h0000_107F;
    tick();
    check("ill_flag",  64'(illegal),       64'd1);
    check("ill_count", 64'(illegal_count), 64'd1);
    check("ill_nopush", 64'(out_valid),    64'd0);
    for (int i = 0; i < 253; i++) tick();
    check("ill_count_254", 64'(illegal_count), 64'd254);
    tick();
    check("ill_count_255", 64'(illegal_count), 64'd255);
    for (int i = 0; i < 46; i++) tick();
    check("ill_count_sat", 64'(illegal_count), 64'd255);
    instr = 32'h0020_A063;
    tick();
    in_valid = 1'b0;
    check("ill_branch_nopush", 64'(out_valid), 64'd0);
    check("ill_count_hold",    64'(illegal_count), 64'd255);

    // Reset with two entries buffered
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h0020_8033; rs1_data = 64'd42;
    tick(); tick();
    in_valid = 1'b0;
    check("pre_rst_full", 64'(in_ready), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_out_valid", 64'(out_valid),     64'd0);
    check("rst2_in_ready",  64'(in_ready),      64'd1);
    check("rst2_illegal",   64'(illegal),       64'd0);
    check("rst2_count",     64'(illegal_count), 64'd0);
    check("rst2_a",         a,                  64'd0);
    out_ready = 1'b1;
    tick();
    check("rst2_stays_empty", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
